mult_array_sched: RTL and testbench

- Sequencer for the pipelined signed multiplier array: DSP and LUT multiplier lanes that share a single clock-enable (en).
- Accepts a job of num_passes operand vectors over a valid/ready handshake and drives the array's shared en.
- Tracks in-flight vectors with a valid/last shadow pipeline matching the multiplier latency; presents products to the downstream accumulator with valid/ready/last.
- Downstream backpressure freezes the whole array through en; no product is ever dropped or duplicated.

---
 rtl/mult_array_sched.sv | 142 ++++++++++++++
 tb/tb_mult_array_sched.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mult_array_sched.sv
// mult_array_sched: sequencer for a pipelined signed multiplier array.
// Accepts a job of num_passes operand vectors and drives the array's shared
// clock enable. A valid/last shadow pipeline, the same depth as the
// multiplier lanes, tracks which array stages hold real products. Downstream
// backpressure freezes the whole array, so no product is dropped or duplicated.
module mult_array_sched #(
  parameter int MULT_LATENCY = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_passes,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mult_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_WIDTH-1:0]  r_n;
  logic [CNT_WIDTH-1:0]  r_acc_cnt;
  logic [CNT_WIDTH-1:0]  r_ret_cnt;
  logic [MULT_LATENCY-1:0] r_vld;
  logic [MULT_LATENCY-1:0] r_lst;

  logic w_in_hs;
  logic w_out_hs;
  logic w_start_acc;
  logic w_last_acc;

  // The array only stalls when a valid product is held at the output and
  // downstream refuses it; empty (bubble) slots keep shifting.
  assign mult_en     = ~(r_vld[MULT_LATENCY-1] & ~out_ready);
  assign in_ready    = (r_state == S_RUN) & mult_en;
  assign out_valid   = r_vld[MULT_LATENCY-1];
  assign out_last    = r_lst[MULT_LATENCY-1];
  assign w_in_hs     = in_valid & in_ready;
  assign w_out_hs    = out_valid & out_ready;
  assign w_start_acc = start & (r_state == S_IDLE);
  assign w_last_acc  = w_in_hs & (r_acc_cnt == (r_n - C_ONE));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (num_passes != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (w_last_acc) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_out_hs & out_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Job length latch and accept/return counters; both counters restart on
  // every accepted start, and otherwise count their own handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n       <= '0;
      r_acc_cnt <= '0;
      r_ret_cnt <= '0;
    end else if (w_start_acc) begin
      r_n       <= num_passes;
      r_acc_cnt <= '0;
      r_ret_cnt <= '0;
    end else begin
      if (w_in_hs) begin
        r_acc_cnt <= r_acc_cnt + C_ONE;
      end
      if (w_out_hs) begin
        r_ret_cnt <= r_ret_cnt + C_ONE;
      end
    end
  end

  // Shadow stage 0 captures whether the array just took a real vector and
  // whether it was the last of the job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld[0] <= 1'b0;
      r_lst[0] <= 1'b0;
    end else if (mult_en) begin
      r_vld[0] <= w_in_hs;
      r_lst[0] <= w_last_acc;
    end
  end

  // Remaining shadow stages move in lockstep with the array's enable.
  for (genvar gi = 1; gi < MULT_LATENCY; gi++) begin : g_shadow
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld[gi] <= 1'b0;
        r_lst[gi] <= 1'b0;
      end else if (mult_en) begin
        r_vld[gi] <= r_vld[gi-1];
        r_lst[gi] <= r_lst[gi-1];
      end
    end
  end

endmodule

// File: tb/tb_mult_array_sched.sv
// Bench for mult_array_sched: models the multiplier array (gated by mult_en)
// and scores every product against a queue of expected results.
module tb_mult_array_sched;

  localparam int L  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] num_passes = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, in_ready, mult_en, out_valid, out_last;

  logic signed [7:0]  a_in = '0;
  logic signed [7:0]  b_in = '0;
  logic signed [15:0] p_pipe [L];

  typedef struct {
    logic signed [15:0] prod;
    logic               last;
  } sb_t;

  sb_t sb_q[$];
  int  out_cycles[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  job_n, job_idx, outs, first_acc_cyc, done_cyc, inrdy_cycles, start_cyc;

  always #5 clk = ~clk;

  mult_array_sched #(.MULT_LATENCY(L), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_passes(num_passes),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mult_en   (mult_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  // Behavioural multiplier array: all lanes share the clock enable.
  always @(posedge clk) begin
    if (mult_en) begin
      p_pipe[0] <= a_in * b_in;
      for (int k = 1; k < L; k++) p_pipe[k] <= p_pipe[k-1];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, then advance past the rising edge.
  task automatic step();
    sb_t e;
    @(negedge clk);
    check_val("mult_en", {31'd0, mult_en}, {31'd0, !(out_valid && !out_ready)});
    if (out_valid && !out_ready) check_val("stall_in_ready", {31'd0, in_ready}, 32'd0);
    if (in_ready) inrdy_cycles++;
    if (in_valid && in_ready) begin
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      e.prod = a_in * b_in;
      e.last = (job_idx == job_n - 1);
      sb_q.push_back(e);
      job_idx++;
    end
    if (out_valid) check_val("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
    if (out_valid && out_ready && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_val("prod", 32'(p_pipe[L-1]), 32'(e.prod));
      check_val("last", {31'd0, out_last}, {31'd0, e.last});
      out_cycles.push_back(cyc);
      outs++;
    end
    if (done) begin
      done_cyc = cyc;
      check_val("busy_at_done", {31'd0, busy}, 32'd1);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_job(input int n, input bit toggle, input int stall_len, input int restart_at);
    int  stall_rem;
    bit  stall_done;
    job_n = n; job_idx = 0; outs = 0; first_acc_cyc = -1; done_cyc = -1;
    inrdy_cycles = 0; out_cycles.delete();
    stall_rem = 0; stall_done = 0;
    start = 1'b1; num_passes = CW'(n); in_valid = 1'b1; out_ready = 1'b1;
    a_in = 8'($urandom); b_in = 8'($urandom);
    start_cyc = cyc;
    step();
    start = 1'b0;
    num_passes = CW'($urandom);
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      in_valid = toggle ? (c % 2 == 1) : 1'b1;
      if (stall_len > 0 && !stall_done && out_valid) begin
        stall_rem = stall_len;
        stall_done = 1;
      end
      out_ready = (stall_rem == 0);
      if (stall_rem > 0) stall_rem--;
      if (c == restart_at) begin
        start = 1'b1; num_passes = CW'(9);
      end else begin
        start = 1'b0;
      end
      a_in = 8'($urandom); b_in = 8'($urandom);
      step();
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check_val("done_seen", {31'd0, done_cyc >= 0}, 32'd1);
    check_val("outputs", 32'(outs), 32'(n));
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    check_val("busy_after", {31'd0, busy}, 32'd0);
    if (n > 0 && outs > 0) check_val("done_timing", 32'(done_cyc), 32'(out_cycles[outs-1] + 1));
  endtask

  initial begin
    // Reset values
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_out_last", {31'd0, out_last}, 32'd0);
    check_val("rst_mult_en", {31'd0, mult_en}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    // N=3, full throughput: latency and in_ready window
    run_job(3, 1'b0, 0, -1);
    check_val("t1_first_acc", 32'(first_acc_cyc), 32'(start_cyc + 1));
    check_val("t1_inrdy_cycles", 32'(inrdy_cycles), 32'd3);
    for (int k = 0; k < 3 && k < outs; k++)
      check_val("t1_out_cycle", 32'(out_cycles[k]), 32'(first_acc_cyc + L + k));

    // N=4 with 3-cycle downstream stall
    run_job(4, 1'b0, 3, -1);

    // N=5 with in_valid toggling
    run_job(5, 1'b1, 0, -1);

    // Empty job
    run_job(0, 1'b0, 0, -1);
    check_val("t4_done_cycle", 32'(done_cyc), 32'(start_cyc + 1));
    check_val("t4_inrdy", 32'(inrdy_cycles), 32'd0);

    // Restart attempt mid-job is ignored
    run_job(3, 1'b0, 0, 1);

    // Reset with products in flight
    job_n = 4; job_idx = 0; first_acc_cyc = -1; inrdy_cycles = 0;
    start = 1'b1; num_passes = CW'(4); in_valid = 1'b0; out_ready = 1'b0;
    step();
    start = 1'b0; in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 20 && !out_valid; c++) step();
    check_val("rst_mid_held", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_mid_busy", {31'd0, busy}, 32'd0);
    check_val("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    sb_q.delete();
    @(posedge clk); #1 rst_n = 1'b1; cyc++;
    out_ready = 1'b1;
    step();
    run_job(2, 1'b0, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
